// File: rtl/sat9_frame_gen.sv
// I/Q frame generator: rounds, shifts and saturates wide signed samples to 9 bits,
// feeds the 18x120 capture memory write port and pulses done after a full frame.
module sat9_frame_gen #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 9,
  parameter int FRAME_LEN = 120,
  parameter int SHIFT_W   = 3
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [IN_W-1:0]    in_i,
  input  logic [IN_W-1:0]    in_q,
  input  logic               in_en,
  output logic [OUT_W-1:0]   SAT9_i,
  output logic [OUT_W-1:0]   SAT9_q,
  output logic               SAT9_en,
  output logic               done,
  output logic               busy,
  output logic [6:0]         sat_cnt
);

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = (IN_W+1)'(-(2**(OUT_W-1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]      in_cnt;
  logic [1:0]            flush_cnt;
  logic [SHIFT_W-1:0]    shift_l;
  logic                  s1_en;
  logic signed [IN_W:0]  s1_i, s1_q;
  logic [OUT_W:0]        sat_i, sat_q;
  logic                  accept, start_ok, clip;

  // Round-half-up then arithmetic shift; IN_W+1 bits leave room for the rounding add.
  function automatic logic signed [IN_W:0] round_shift(input logic [IN_W-1:0] x,
                                                       input logic [SHIFT_W-1:0] sh);
    logic signed [IN_W:0] xe;
    logic signed [IN_W:0] r;
    xe = {x[IN_W-1], x};
    if (sh == '0) begin
      r = '0;
    end else begin
      r = (IN_W+1)'(1) << (sh - SHIFT_W'(1));
    end
    return (xe + r) >>> sh;
  endfunction

  // Returns {clipped, value} clamped to the signed OUT_W range.
  function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] y);
    if (y > SAT_MAX) begin
      return {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (y < SAT_MIN) begin
      return {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      return {1'b0, y[OUT_W-1:0]};
    end
  endfunction

  assign accept   = (state == RUN) && in_en;
  assign start_ok = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FLUSH holds until the last sample has left stage 2 plus one more cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = RUN;
        else       next_state = IDLE;
      end
      RUN: begin
        if (in_en && (in_cnt == LAST_IDX)) next_state = FLUSH;
        else                               next_state = RUN;
      end
      FLUSH: begin
        if (flush_cnt == 2'd2) next_state = DONE;
        else                   next_state = FLUSH;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      in_cnt    <= '0;
      flush_cnt <= 2'd0;
      shift_l   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (start_ok) begin
        shift_l <= shift;
        in_cnt  <= '0;
      end else if (accept) begin
        in_cnt  <= in_cnt + CNT_W'(1);
      end
      if (state == FLUSH) flush_cnt <= flush_cnt + 2'd1;
      else                flush_cnt <= 2'd0;
      done <= (next_state == DONE);
      busy <= (next_state != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_en <= 1'b0;
      s1_i  <= '0;
      s1_q  <= '0;
    end else begin
      s1_en <= accept;
      if (accept) begin
        s1_i <= round_shift(in_i, shift_l);
        s1_q <= round_shift(in_q, shift_l);
      end
    end
  end

  always_comb begin
    sat_i = saturate(s1_i);
    sat_q = saturate(s1_q);
    clip  = sat_i[OUT_W] | sat_q[OUT_W];
  end

  // Data outputs hold between samples; the memory only looks at them when SAT9_en is set.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      SAT9_en <= 1'b0;
      SAT9_i  <= '0;
      SAT9_q  <= '0;
      sat_cnt <= '0;
    end else begin
      SAT9_en <= s1_en;
      if (s1_en) begin
        SAT9_i <= sat_i[OUT_W-1:0];
        SAT9_q <= sat_q[OUT_W-1:0];
      end
      if (start_ok) begin
        sat_cnt <= '0;
      end else if (s1_en && clip) begin
        sat_cnt <= sat_cnt + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_sat9_frame_gen.sv
// Scoreboard bench for sat9_frame_gen: stimulus pushes expected samples,
// a negedge monitor pops and compares them and times the done pulse.
module tb_sat9_frame_gen;

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  shift = 3'd0;
  logic [15:0] in_i = 16'd0;
  logic [15:0] in_q = 16'd0;
  logic        in_en = 1'b0;
  logic [8:0]  SAT9_i, SAT9_q;
  logic        SAT9_en, done, busy;
  logic [6:0]  sat_cnt;

  sat9_frame_gen dut (
    .clk(clk), .rstb(rstb), .start(start), .shift(shift),
    .in_i(in_i), .in_q(in_q), .in_en(in_en),
    .SAT9_i(SAT9_i), .SAT9_q(SAT9_q), .SAT9_en(SAT9_en),
    .done(done), .busy(busy), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] i;
    logic [8:0] q;
    logic [6:0] sc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks, failures;
  int   cyc, frame_en, done_cnt, last_en_cyc, exp_sat;
  int   saved_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: compares each presented sample and the timing of done.
  always @(negedge clk) begin
    if (!rstb) begin
      sb.delete();
      frame_en = 0;
    end else begin
      if (SAT9_en) begin
        frame_en++;
        last_en_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_en", int'(SAT9_en), 0);
        end else begin
          e = sb.pop_front();
          check("sat9_i", int'(SAT9_i), int'(e.i));
          check("sat9_q", int'(SAT9_q), int'(e.q));
          check("sat_cnt", int'(sat_cnt), int'(e.sc));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_delay", cyc - last_en_cyc, 2);
        check("frame_en_count", frame_en, 120);
        frame_en = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model(input int x, input int sh, output bit clip);
    int y;
    y = (x + ((sh == 0) ? 0 : (1 << (sh - 1)))) >>> sh;
    clip = 1'b0;
    if (y > 255) begin
      y = 255;
      clip = 1'b1;
    end else if (y < -256) begin
      y = -256;
      clip = 1'b1;
    end
    return y & 511;
  endfunction

  task automatic send(input int i, input int q, input int ei, input int eq, input bit clip);
    exp_t x;
    if (clip) exp_sat++;
    x.i  = ei[8:0];
    x.q  = eq[8:0];
    x.sc = exp_sat[6:0];
    sb.push_back(x);
    in_i  = i[15:0];
    in_q  = q[15:0];
    in_en = 1'b1;
    tick();
    in_en = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_m(input int i, input int q, input int sh);
    bit ci, cq;
    int ei, eq;
    ei = model(i, sh, ci);
    eq = model(q, sh, cq);
    send(i, q, ei, eq, ci | cq);
  endtask

  task automatic send_ignored(input int i);
    in_i  = i[15:0];
    in_q  = i[15:0];
    in_en = 1'b1;
    tick();
    in_en = 1'b0;
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic start_frame(input int sh);
    start   = 1'b1;
    shift   = sh[2:0];
    tick();
    start   = 1'b0;
    shift   = 3'd7;
    exp_sat = 0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", int'(done), 1);
    tick();
    check("busy_after_done", int'(busy), 0);
    check("done_single", int'(done), 0);
  endtask

  task automatic async_reset();
    #2;
    rstb = 1'b0;
    #1;
    check("rst_sat9_i", int'(SAT9_i), 0);
    check("rst_sat9_q", int'(SAT9_q), 0);
    check("rst_sat9_en", int'(SAT9_en), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sat_cnt", int'(sat_cnt), 0);
    @(negedge clk);
    tick();
    rstb    = 1'b1;
    exp_sat = 0;
    tick();
  endtask

  initial begin
    tick();
    async_reset();

    // Frame A: passthrough, saturation boundaries, start ignored in RUN.
    start_frame(0);
    send(100, -100, 'h064, 'h19C, 1'b0);
    send(300, -300, 'h0FF, 'h100, 1'b1);
    start = 1'b1;
    shift = 3'd5;
    tick();
    start = 1'b0;
    check("busy_during_run", int'(busy), 1);
    send(255, -256, 'h0FF, 'h100, 1'b0);
    for (int k = 3; k < 120; k++) send_m(rnd16() >>> 6, rnd16() >>> 6, 0);
    wait_done();
    for (int k = 0; k < 3; k++) send_ignored(77);
    repeat (4) tick();
    check("no_en_after_done", frame_en, 0);
    check("done_count_a", done_cnt, 1);
    check("sat_cnt_hold", int'(sat_cnt), exp_sat);

    // Frame B: rounding with shift 2, then abort by reset after 60 samples.
    start_frame(2);
    send(5, -6, 1, 'h1FF, 1'b0);
    send(32767, 0, 'h0FF, 0, 1'b1);
    for (int k = 2; k < 60; k++) send_m(rnd16(), rnd16(), 2);
    saved_done = done_cnt;
    async_reset();
    repeat (10) tick();
    check("no_done_after_abort", done_cnt, saved_done);
    check("no_en_after_abort", frame_en, 0);

    // Frame C: shift 1 rounding of -1, full new frame after the abort.
    start_frame(1);
    send(-1, -1, 0, 0, 1'b0);
    for (int k = 1; k < 120; k++) send_m(rnd16() >>> 5, rnd16() >>> 5, 1);
    wait_done();
    repeat (3) tick();
    check("done_count_c", done_cnt, saved_done + 1);
    check("sat_cnt_frame_c", int'(sat_cnt), exp_sat);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
